apb_timer: RTL and testbench
============================

APB_TIMER -- requirements
Module: apb_timer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data and counter width.
REQ-003 HCLK  input  1  clock; all state updates on the rising edge.
REQ-004 HRESETn  input  1  reset, asynchronous, active-low.
REQ-005 PSEL  input  1  slave select from the AHB-to-APB bridge.
REQ-006 PENABLE  input  1  APB access (enable) phase.
REQ-007 PADDR  input  ADDR_WIDTH  byte address; only PADDR[4:2] is decoded.
REQ-008 PWRITE  input  1  1 = write, 0 = read.
REQ-009 PWDATA  input  DATA_WIDTH  write data.
REQ-010 PRDATA  output  DATA_WIDTH  read data to the bridge.
REQ-011 IRQ  output  1  level interrupt request.

Function
REQ-012 SHALL be an APB2 slave with no PREADY and no PSLVERR; every access completes in setup + enable (2 cycles).
REQ-013 Register map (offset, access):
- 0x00 CTRL, RW: bit0 EN, bit1 PERIODIC, bit2 IE; other bits read 0.
- 0x04 LOAD, RW.
- 0x08 VALUE, RO.
- 0x0C INTSTAT, bit0 W1C.
- 0x10 PRESCALE, RW (see REQ-027).
- All other offsets read 0 and ignore writes.
REQ-014 A write SHALL commit on the rising edge where PSEL & PENABLE & PWRITE is high; the new value is visible the following cycle.
REQ-015 PRDATA SHALL be combinationally decoded from PADDR when PSEL & !PWRITE, and 0 otherwise.
REQ-016 The FSM SHALL have two states:
- STOPPED: VALUE holds.
- COUNTING: VALUE decrements by 1 per tick.
REQ-017 STOPPED -> COUNTING when CTRL.EN is written to 1; COUNTING -> STOPPED when EN is written to 0 or on one-shot expiry.
REQ-018 A tick SHALL occur every cycle in COUNTING, unless modified by REQ-027.
REQ-019 On a tick with VALUE == 0:
- INTSTAT[0] is set.
- If PERIODIC = 1: VALUE reloads from LOAD.
- If PERIODIC = 0: VALUE stays 0, EN clears, and the FSM enters STOPPED.
REQ-020 A LOAD write SHALL also load VALUE in the same edge, and SHALL take priority over a simultaneous tick or reload.
REQ-021 If a W1C to INTSTAT and an expiry occur on the same edge, INTSTAT[0] SHALL end at 1 (set wins).
REQ-022 IRQ SHALL equal INTSTAT[0] & CTRL.IE and be registered-source glitch-free (combination of flops only).
REQ-023 VALUE arithmetic SHALL be unsigned DATA_WIDTH with no underflow wrap; 0 is the expiry point. With LOAD = N, the period is N+1 ticks.

Reset
REQ-024 On HRESETn low, the following SHALL be cleared immediately, independent of HCLK: FSM = STOPPED, CTRL = 0, LOAD = 0, VALUE = 0, INTSTAT = 0, PRESCALE = 0, prescale counter = 0, IRQ = 0.
REQ-025 PRDATA SHALL be 0 during reset.
REQ-026 Reset asserted mid-count SHALL abort counting; after release, no tick or interrupt occurs until EN is rewritten.

Configuration
REQ-027 Macro APB_TIMER_PRESCALER_EN:
- Defined: PRESCALE[7:0] is RW at 0x10. An 8-bit prescale counter produces one tick every PRESCALE+1 cycles in COUNTING. The prescale counter clears on entry to COUNTING and on any LOAD write.
- Undefined: 0x10 reads 0, writes are ignored, and a tick occurs every cycle.

Verification
REQ-028 Reset check: assert HRESETn low mid-count -> PRDATA = 0, IRQ = 0; after release, reading 0x08 returns 0 and 0x00 returns 0.
REQ-029 One-shot: write LOAD = 5, CTRL = 0x5 -> VALUE counts 5..0; INTSTAT = 1 and IRQ = 1 on the 6th tick; CTRL reads 0x4; VALUE holds at 0.
REQ-030 Periodic: LOAD = 3, CTRL = 0x7 -> IRQ sets every 4 cycles; after W1C of INTSTAT = 1, IRQ drops the next cycle and resets at the next expiry.
REQ-031 Collisions:
- W1C on the same edge as expiry -> INTSTAT reads 1.
- LOAD = 9 written on the expiry edge -> VALUE = 9.
REQ-032 With APB_TIMER_PRESCALER_EN, PRESCALE = 2, LOAD = 1 -> expiry after 6 cycles; without the macro -> 0x10 reads 0 after a write of 0xFF.
REQ-033 Decode: read offsets 0x14 and 0x1C -> 0; write 0xFFFFFFFF to VALUE -> VALUE unchanged.

Source files
------------

// File: rtl/apb_timer.sv
// APB2 down-counting timer: CTRL/LOAD/VALUE/INTSTAT registers, one-shot or periodic, level IRQ.
// Optional prescaler enabled by defining APB_TIMER_PRESCALER_EN (PRESCALE register at 0x10).
module apb_timer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  IRQ
);

  typedef enum logic {
    STOPPED  = 1'b0,
    COUNTING = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [2:0]            ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0] load_q, load_d;
  logic [DATA_WIDTH-1:0] value_q, value_d;
  logic                  intstat_q, intstat_d;

  logic [2:0] reg_sel;
  logic       wr, wr_ctrl, wr_load, wr_int;
  logic       tick, expire;
  logic       unused_paddr;

  assign reg_sel      = PADDR[4:2];
  assign unused_paddr = ^{PADDR[ADDR_WIDTH-1:5], PADDR[1:0]};
  assign wr           = PSEL & PENABLE & PWRITE;
  assign wr_ctrl      = wr && (reg_sel == 3'd0);
  assign wr_load      = wr && (reg_sel == 3'd1);
  assign wr_int       = wr && (reg_sel == 3'd3);

`ifdef APB_TIMER_PRESCALER_EN
  logic [7:0] prescale_q, prescale_d;
  logic [7:0] pcnt_q, pcnt_d;
  logic       wr_presc;

  assign wr_presc = wr && (reg_sel == 3'd4);
  // >= rather than == so a PRESCALE shrunk mid-count cannot strand the counter
  assign tick     = (state_q == COUNTING) && (pcnt_q >= prescale_q);
`else
  assign tick     = (state_q == COUNTING);
`endif

  assign expire = tick && (value_q == '0);

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    load_d    = load_q;
    value_d   = value_q;
    intstat_d = intstat_q;

    if (tick) begin
      if (value_q == '0) begin
        if (ctrl_q[1]) begin
          value_d = load_q;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = STOPPED;
        end
      end else begin
        value_d = value_q - DATA_WIDTH'(1);
      end
    end

    // Bus writes are applied after the tick so they override it
    if (wr_ctrl) begin
      ctrl_d  = PWDATA[2:0];
      state_d = PWDATA[0] ? COUNTING : STOPPED;
    end
    if (wr_load) begin
      load_d  = PWDATA;
      value_d = PWDATA;
    end

    if (wr_int && PWDATA[0]) intstat_d = 1'b0;
    if (expire)              intstat_d = 1'b1;
  end

`ifdef APB_TIMER_PRESCALER_EN
  always_comb begin
    prescale_d = prescale_q;
    pcnt_d     = pcnt_q;
    if (wr_presc) prescale_d = PWDATA[7:0];
    if (state_q == COUNTING) pcnt_d = tick ? 8'd0 : pcnt_q + 8'd1;
    if ((state_q == STOPPED && wr_ctrl && PWDATA[0]) || wr_load) pcnt_d = 8'd0;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      prescale_q <= '0;
      pcnt_q     <= '0;
    end else begin
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
    end
  end
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= STOPPED;
      ctrl_q    <= '0;
      load_q    <= '0;
      value_q   <= '0;
      intstat_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      load_q    <= load_d;
      value_q   <= value_d;
      intstat_q <= intstat_d;
    end
  end

  always_comb begin
    PRDATA = '0;
    if (HRESETn && PSEL && !PWRITE) begin
      case (reg_sel)
        3'd0:    PRDATA[2:0] = ctrl_q;
        3'd1:    PRDATA      = load_q;
        3'd2:    PRDATA      = value_q;
        3'd3:    PRDATA[0]   = intstat_q;
`ifdef APB_TIMER_PRESCALER_EN
        3'd4:    PRDATA[7:0] = prescale_q;
`endif
        default: PRDATA      = '0;
      endcase
    end
  end

  assign IRQ = intstat_q & ctrl_q[2];

endmodule

// File: tb/tb_apb_timer.sv
// Self-checking bench for apb_timer: randomized one-shot/periodic runs against an arithmetic
// model (value = f(ticks elapsed)), collision cases, decode and reset behaviour.
module tb_apb_timer;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic [31:0] PADDR = '0;
  logic        PWRITE = 1'b0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        IRQ;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  apb_timer #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .IRQ(IRQ)
  );

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc = cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  // Called 1 time unit after a rising edge; returns 1 unit after the commit edge.
  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    step();
    PENABLE = 1'b1;
    step();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    step();
    PENABLE = 1'b1;
    #1 d = PRDATA;
    step();
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // Setup-phase-only sample of the combinational read path; does not advance the clock.
  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    #1 d = PRDATA;
    PSEL = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    PSEL = 1'b1; PADDR = 32'h4;
    #1;
    total++; if (PRDATA !== 32'h0) begin bad++; $display("FAIL reset_prdata got=%0h want=0", PRDATA); end
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL reset_irq got=%0b want=0", IRQ); end
    PSEL = 1'b0;
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    step();
    for (int unsigned i = 0; i < 5; i++) begin
      apb_read(32'(i * 4), r);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL reset_reg off=%0h got=%0h want=0", i * 4, r); end
    end
    apb_write(32'h4, 32'd1);
    apb_write(32'h0, 32'h7);
    repeat (3) step();
    total++; if (IRQ !== 1'b1) begin bad++; $display("FAIL premid_irq got=%0b want=1", IRQ); end
    apb_write(32'h4, 32'd20);
    repeat (2) step();
    HRESETn = 1'b0;
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = 32'h4;
    #1;
    total++; if (PRDATA !== 32'h0) begin bad++; $display("FAIL midreset_prdata got=%0h want=0", PRDATA); end
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL midreset_irq got=%0b want=0", IRQ); end
    PSEL = 1'b0;
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    apb_read(32'h8, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL postreset_value got=%0h want=0", r); end
    apb_read(32'h0, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL postreset_ctrl got=%0h want=0", r); end
    repeat (30) step();
    apb_read(32'hC, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL postreset_intstat got=%0h want=0", r); end
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL postreset_irq got=%0b want=0", IRQ); end
  endtask

  task automatic test_oneshot();
    int unsigned n, ev, es;
    logic        ie;
    logic [31:0] v, s, c;
    for (int t = 0; t < 5; t++) begin
      n  = (t == 0) ? 5 : $urandom_range(0, 12);
      ie = (t == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      apb_write(32'h4, n);
      apb_write(32'h0, {29'd0, ie, 2'b01});
      for (int unsigned k = 0; k <= n + 3; k++) begin
        peek(32'h8, v);
        peek(32'hC, s);
        ev = (k <= n) ? n - k : 0;
        es = (k >= n + 1) ? 1 : 0;
        total++; if (v !== ev) begin bad++; $display("FAIL oneshot_value n=%0d k=%0d got=%0d want=%0d", n, k, v, ev); end
        total++; if (s !== es) begin bad++; $display("FAIL oneshot_intstat n=%0d k=%0d got=%0d want=%0d", n, k, s, es); end
        total++; if (IRQ !== (es[0] & ie)) begin bad++; $display("FAIL oneshot_irq n=%0d k=%0d got=%0b want=%0b", n, k, IRQ, es[0] & ie); end
        step();
      end
      apb_read(32'h0, c);
      total++; if (c !== {29'd0, ie, 2'b00}) begin bad++; $display("FAIL oneshot_ctrl got=%0h want=%0h", c, {29'd0, ie, 2'b00}); end
      apb_write(32'hC, 32'h1);
    end
  endtask

  task automatic test_periodic();
    int unsigned n, p, k, e0, ec, ev, es, d;
    logic [31:0] v, s;
    for (int t = 0; t < 4; t++) begin
      n = (t == 0) ? 3 : $urandom_range(0, 6);
      p = n + 1;
      apb_write(32'h4, n);
      apb_write(32'h0, 32'h7);
      e0 = cyc;
      ec = 1;
      for (int ph = 0; ph < 2; ph++) begin
        for (int unsigned i = 0; i < 2 * p + 2; i++) begin
          k = cyc - e0;
          peek(32'h8, v);
          peek(32'hC, s);
          ev = n - (k % p);
          es = ((k / p) > ((ec - 1) / p)) ? 1 : 0;
          total++; if (v !== ev) begin bad++; $display("FAIL periodic_value n=%0d k=%0d got=%0d want=%0d", n, k, v, ev); end
          total++; if (s !== es) begin bad++; $display("FAIL periodic_intstat n=%0d k=%0d got=%0d want=%0d", n, k, s, es); end
          total++; if (IRQ !== es[0]) begin bad++; $display("FAIL periodic_irq n=%0d k=%0d got=%0b want=%0b", n, k, IRQ, es[0]); end
          step();
        end
        if (ph == 0) begin
          d = $urandom_range(0, n);
          repeat (d) step();
          apb_write(32'hC, 32'h1);
          ec = cyc - e0;
        end
      end
      apb_write(32'h0, 32'h0);
      apb_write(32'hC, 32'h1);
    end
  endtask

  task automatic test_collisions();
    int unsigned e0;
    logic [31:0] v, s;
    apb_write(32'h4, 32'd3);
    apb_write(32'h0, 32'h7);
    e0 = cyc;
    repeat (2) step();
    apb_write(32'hC, 32'h1);
    peek(32'hC, s);
    total++; if (s !== 32'h1) begin bad++; $display("FAIL w1c_vs_expiry_intstat k=%0d got=%0h want=1", cyc - e0, s); end
    total++; if (IRQ !== 1'b1) begin bad++; $display("FAIL w1c_vs_expiry_irq got=%0b want=1", IRQ); end
    apb_write(32'hC, 32'h1);
    peek(32'hC, s);
    peek(32'h8, v);
    total++; if (s !== 32'h0) begin bad++; $display("FAIL w1c_plain_intstat k=%0d got=%0h want=0", cyc - e0, s); end
    total++; if (v !== 32'd1) begin bad++; $display("FAIL w1c_plain_value k=%0d got=%0d want=1", cyc - e0, v); end
    apb_write(32'h4, 32'd9);
    peek(32'h8, v);
    total++; if (v !== 32'd9) begin bad++; $display("FAIL load_vs_expiry k=%0d got=%0d want=9", cyc - e0, v); end
    step();
    peek(32'h8, v);
    total++; if (v !== 32'd8) begin bad++; $display("FAIL load_then_count got=%0d want=8", v); end
    apb_write(32'h0, 32'h0);
    apb_write(32'hC, 32'h1);
  endtask

  task automatic test_decode();
    logic [31:0] ld, r;
    ld = $urandom;
    apb_write(32'h4, ld);
    apb_write(32'h8, 32'hFFFF_FFFF);
    apb_read(32'h8, r);
    total++; if (r !== ld) begin bad++; $display("FAIL value_ro got=%0h want=%0h", r, ld); end
    apb_read(32'h104, r);
    total++; if (r !== ld) begin bad++; $display("FAIL alias_load got=%0h want=%0h", r, ld); end
    for (int unsigned a = 5; a < 8; a++) begin
      apb_write(32'(a * 4), 32'hFFFF_FFFF);
      apb_read(32'(a * 4), r);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL unmapped off=%0h got=%0h want=0", a * 4, r); end
    end
    apb_write(32'h0, 32'hFFFF_FFF6);
    apb_read(32'h0, r);
    total++; if (r !== 32'h6) begin bad++; $display("FAIL ctrl_mask got=%0h want=6", r); end
    apb_read(32'h8, r);
    total++; if (r !== ld) begin bad++; $display("FAIL ctrl_no_en_holds got=%0h want=%0h", r, ld); end
    apb_write(32'h0, 32'h0);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = 32'h4;
    #1;
    total++; if (PRDATA !== 32'h0) begin bad++; $display("FAIL prdata_on_write got=%0h want=0", PRDATA); end
    PSEL = 1'b0; PWRITE = 1'b0;
    #1;
    total++; if (PRDATA !== 32'h0) begin bad++; $display("FAIL prdata_unselected got=%0h want=0", PRDATA); end
    step();
  endtask

  task automatic test_prescale();
    logic [31:0] r;
`ifdef APB_TIMER_PRESCALER_EN
    int unsigned n, p, tk, ev, es;
    logic [31:0] v, s;
    apb_write(32'h10, 32'h0000_0102);
    apb_read(32'h10, r);
    total++; if (r !== 32'h2) begin bad++; $display("FAIL prescale_rw got=%0h want=2", r); end
    for (int t = 0; t < 4; t++) begin
      p = (t == 0) ? 2 : $urandom_range(0, 4);
      n = (t == 0) ? 1 : $urandom_range(0, 3);
      apb_write(32'h10, p);
      apb_write(32'h4, n);
      apb_write(32'h0, 32'h5);
      for (int unsigned k = 0; k <= (n + 1) * (p + 1) + 2; k++) begin
        peek(32'h8, v);
        peek(32'hC, s);
        tk = k / (p + 1);
        ev = (tk <= n) ? n - tk : 0;
        es = (tk >= n + 1) ? 1 : 0;
        total++; if (v !== ev) begin bad++; $display("FAIL presc_value p=%0d n=%0d k=%0d got=%0d want=%0d", p, n, k, v, ev); end
        total++; if (s !== es) begin bad++; $display("FAIL presc_intstat p=%0d n=%0d k=%0d got=%0d want=%0d", p, n, k, s, es); end
        step();
      end
      apb_write(32'hC, 32'h1);
    end
    apb_write(32'h10, 32'h0);
`else
    apb_write(32'h10, 32'hFF);
    apb_read(32'h10, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL prescale_absent got=%0h want=0", r); end
`endif
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_collisions();
    test_decode();
    test_prescale();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
